// File: rtl/rpr0521rs_pkg.sv
// Shared definitions for the RPR0521RS I2C target: register map, reset values,
// FSM state encoding and small helpers.
package rpr0521rs_pkg;

    localparam logic [7:0] REG_SYS_CTRL    = 8'h40;
    localparam logic [7:0] REG_MODE_CTRL   = 8'h41;
    localparam logic [7:0] REG_ALS_PS_CTRL = 8'h42;
    localparam logic [7:0] REG_PS_CTRL     = 8'h43;
    localparam logic [7:0] REG_PS_LSB      = 8'h44;
    localparam logic [7:0] REG_PS_MSB      = 8'h45;
    localparam logic [7:0] REG_ALS0_LSB    = 8'h46;
    localparam logic [7:0] REG_ALS0_MSB    = 8'h47;
    localparam logic [7:0] REG_ALS1_LSB    = 8'h48;
    localparam logic [7:0] REG_ALS1_MSB    = 8'h49;

    localparam logic [7:0] MODE_CTRL_RST   = 8'h00;
    localparam logic [7:0] ALS_PS_CTRL_RST = 8'h02;
    localparam logic [7:0] PS_CTRL_RST     = 8'h01;
    localparam logic [7:0] PTR_RST         = 8'h40;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h38;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RACK      = 4'd8
    } tgt_state_e;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

endpackage

// File: rtl/rpr0521rs_i2c_target_i2c_bus_sync.sv
// SCL/SDA synchroniser with edge and START/STOP detection.
// Optional 3-sample majority glitch filter when I2C_TGT_GLITCH_FILTER_EN is defined.
module i2c_bus_sync
    import rpr0521rs_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_o,
    output logic stop_o
);

    logic [SYNC_STAGES-1:0] scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q;
    logic                   scl_f_s;
    logic                   sda_f_s;
    logic                   scl_prev_q;
    logic                   sda_prev_q;

    // Synchroniser chains; an idle bus reads high so they reset to ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= {SYNC_STAGES{1'b1}};
            sda_sync_q <= {SYNC_STAGES{1'b1}};
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        end
    end

`ifdef I2C_TGT_GLITCH_FILTER_EN
    logic [1:0] scl_win_q;
    logic [1:0] sda_win_q;
    logic       scl_flt_q;
    logic       sda_flt_q;

    // Majority of the last three samples: a single-cycle pulse never wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_win_q <= 2'b11;
            sda_win_q <= 2'b11;
            scl_flt_q <= 1'b1;
            sda_flt_q <= 1'b1;
        end else begin
            scl_win_q <= {scl_win_q[0], scl_sync_q[SYNC_STAGES-1]};
            sda_win_q <= {sda_win_q[0], sda_sync_q[SYNC_STAGES-1]};
            scl_flt_q <= maj3({scl_win_q, scl_sync_q[SYNC_STAGES-1]});
            sda_flt_q <= maj3({sda_win_q, sda_sync_q[SYNC_STAGES-1]});
        end
    end

    assign scl_f_s = scl_flt_q;
    assign sda_f_s = sda_flt_q;
`else
    assign scl_f_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_f_s = sda_sync_q[SYNC_STAGES-1];
`endif

    // Previous-sample registers for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_f_s;
            sda_prev_q <= sda_f_s;
        end
    end

    assign sda_o      = sda_f_s;
    assign scl_rise_o = scl_f_s & ~scl_prev_q;
    assign scl_fall_o = ~scl_f_s & scl_prev_q;
    assign start_o    = scl_f_s & scl_prev_q & sda_prev_q & ~sda_f_s;
    assign stop_o     = scl_f_s & scl_prev_q & ~sda_prev_q & sda_f_s;

endmodule

// File: rtl/rpr0521rs_i2c_target.sv
// I2C target emulating the RPR0521RS proximity/ALS register map.
// Build option: I2C_TGT_GLITCH_FILTER_EN enables the input glitch filter in i2c_bus_sync.
module rpr0521rs_i2c_target
    import rpr0521rs_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEV_ADDR_DEFAULT,
    parameter logic [7:0] PART_ID     = 8'h0A,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] prox_val,
    input  logic [15:0] als0_val,
    input  logic [15:0] als1_val,
    output logic [7:0]  mode_ctrl,
    output logic [7:0]  als_ps_ctrl,
    output logic [7:0]  ps_ctrl,
    output logic        wr_strobe,
    output logic        busy
);

    logic        sda_s;
    logic        scl_rise_s;
    logic        scl_fall_s;
    logic        start_s;
    logic        stop_s;
    logic [7:0]  byte_s;
    logic [7:0]  rd_cur_s;
    logic [7:0]  rd_next_s;

    tgt_state_e  state_q;
    logic [2:0]  cnt_q;
    logic        phase_q;
    logic        rw_q;
    logic [6:0]  shift_q;
    logic [7:0]  ptr_q;
    logic [7:0]  tx_q;
    logic [47:0] snap_q;
    logic [7:0]  mode_q;
    logic [7:0]  als_ps_q;
    logic [7:0]  ps_q;
    logic        sda_oe_q;
    logic        wr_strobe_q;

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .scl_i      (scl),
        .sda_i      (sda_in),
        .sda_o      (sda_s),
        .scl_rise_o (scl_rise_s),
        .scl_fall_o (scl_fall_s),
        .start_o    (start_s),
        .stop_o     (stop_s)
    );

    // Sensor bytes come from the snapshot so a multi-byte read never tears.
    function automatic logic [7:0] read_byte(input logic [7:0] a);
        case (a)
            REG_SYS_CTRL:    return {2'b00, PART_ID[5:0]};
            REG_MODE_CTRL:   return mode_q;
            REG_ALS_PS_CTRL: return als_ps_q;
            REG_PS_CTRL:     return ps_q;
            REG_PS_LSB:      return snap_q[7:0];
            REG_PS_MSB:      return snap_q[15:8];
            REG_ALS0_LSB:    return snap_q[23:16];
            REG_ALS0_MSB:    return snap_q[31:24];
            REG_ALS1_LSB:    return snap_q[39:32];
            REG_ALS1_MSB:    return snap_q[47:40];
            default:         return 8'h00;
        endcase
    endfunction

    assign byte_s    = {shift_q, sda_s};
    assign rd_cur_s  = read_byte(ptr_q);
    assign rd_next_s = read_byte(ptr_q + 8'd1);

    // Protocol FSM. ACK states use phase_q: first SCL fall drives ACK, second ends it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            phase_q     <= 1'b0;
            rw_q        <= 1'b0;
            shift_q     <= 7'd0;
            ptr_q       <= PTR_RST;
            tx_q        <= 8'h00;
            snap_q      <= 48'h0;
            mode_q      <= MODE_CTRL_RST;
            als_ps_q    <= ALS_PS_CTRL_RST;
            ps_q        <= PS_CTRL_RST;
            sda_oe_q    <= 1'b0;
            wr_strobe_q <= 1'b0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (start_s) begin
                state_q  <= ST_ADDR;
                cnt_q    <= 3'd0;
                phase_q  <= 1'b0;
                sda_oe_q <= 1'b0;
            end else if (stop_s) begin
                state_q  <= ST_IDLE;
                phase_q  <= 1'b0;
                sda_oe_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: sda_oe_q <= 1'b0;
                    ST_ADDR: begin
                        if (scl_rise_s) begin
                            shift_q <= {shift_q[5:0], sda_s};
                            cnt_q   <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                if (shift_q == DEV_ADDR) begin
                                    state_q <= ST_ADDR_ACK;
                                    phase_q <= 1'b0;
                                    rw_q    <= sda_s;
                                    if (sda_s) begin
                                        snap_q <= {als1_val, als0_val, prox_val};
                                    end
                                end else begin
                                    state_q  <= ST_IDLE;
                                    sda_oe_q <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall_s) begin
                            if (!phase_q) begin
                                sda_oe_q <= 1'b1;
                                phase_q  <= 1'b1;
                            end else begin
                                phase_q <= 1'b0;
                                cnt_q   <= 3'd0;
                                if (rw_q) begin
                                    tx_q     <= rd_cur_s;
                                    sda_oe_q <= ~rd_cur_s[7];
                                    state_q  <= ST_RDATA;
                                end else begin
                                    sda_oe_q <= 1'b0;
                                    state_q  <= ST_PTR;
                                end
                            end
                        end
                    end
                    ST_PTR: begin
                        if (scl_rise_s) begin
                            shift_q <= {shift_q[5:0], sda_s};
                            cnt_q   <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                ptr_q   <= byte_s;
                                state_q <= ST_PTR_ACK;
                                phase_q <= 1'b0;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (scl_rise_s) begin
                            shift_q <= {shift_q[5:0], sda_s};
                            cnt_q   <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                case (ptr_q)
                                    REG_MODE_CTRL:   mode_q   <= byte_s;
                                    REG_ALS_PS_CTRL: als_ps_q <= byte_s;
                                    REG_PS_CTRL:     ps_q     <= byte_s;
                                    default:         ;
                                endcase
                                wr_strobe_q <= 1'b1;
                                ptr_q       <= ptr_q + 8'd1;
                                state_q     <= ST_WDATA_ACK;
                                phase_q     <= 1'b0;
                            end
                        end
                    end
                    ST_PTR_ACK, ST_WDATA_ACK: begin
                        if (scl_fall_s) begin
                            if (!phase_q) begin
                                sda_oe_q <= 1'b1;
                                phase_q  <= 1'b1;
                            end else begin
                                sda_oe_q <= 1'b0;
                                phase_q  <= 1'b0;
                                cnt_q    <= 3'd0;
                                state_q  <= ST_WDATA;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (scl_rise_s) begin
                            cnt_q <= cnt_q + 3'd1;
                            if (cnt_q == 3'd7) begin
                                state_q <= ST_RACK;
                                phase_q <= 1'b0;
                            end
                        end else if (scl_fall_s) begin
                            tx_q     <= {tx_q[6:0], 1'b0};
                            sda_oe_q <= ~tx_q[6];
                        end
                    end
                    ST_RACK: begin
                        if (scl_fall_s) begin
                            if (phase_q) begin
                                phase_q  <= 1'b0;
                                cnt_q    <= 3'd0;
                                sda_oe_q <= ~tx_q[7];
                                state_q  <= ST_RDATA;
                            end else begin
                                sda_oe_q <= 1'b0;
                            end
                        end else if (scl_rise_s) begin
                            if (sda_s) begin
                                state_q  <= ST_IDLE;
                                sda_oe_q <= 1'b0;
                            end else begin
                                phase_q <= 1'b1;
                                ptr_q   <= ptr_q + 8'd1;
                                tx_q    <= rd_next_s;
                            end
                        end
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        sda_oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sda_oe      = sda_oe_q;
    assign mode_ctrl   = mode_q;
    assign als_ps_ctrl = als_ps_q;
    assign ps_ctrl     = ps_q;
    assign wr_strobe   = wr_strobe_q;
    assign busy        = (state_q != ST_IDLE) && (state_q != ST_ADDR);

endmodule

// File: tb/tb_rpr0521rs_i2c_target.sv
// Self-checking bench for rpr0521rs_i2c_target: bit-banged I2C master plus a
// register-map reference model.
`timescale 1ns/1ps
module tb_rpr0521rs_i2c_target;

    localparam int         Q   = 8;
    localparam logic [6:0] DEV = 7'h38;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_in;
    logic        sda_oe;
    logic [15:0] prox_val = 16'h0;
    logic [15:0] als0_val = 16'h0;
    logic [15:0] als1_val = 16'h0;
    logic [7:0]  mode_ctrl, als_ps_ctrl, ps_ctrl;
    logic        wr_strobe, busy;

    int n_checks = 0;
    int n_fail = 0;
    int strobe_cnt = 0;
    int oe_cnt = 0;
    int busy_cnt = 0;

    logic [7:0]  m_mode = 8'h00, m_alsps = 8'h02, m_ps = 8'h01, m_ptr = 8'h40;
    logic [47:0] m_snap = 48'h0;

    assign sda_in = sda_m & ~sda_oe;

    rpr0521rs_i2c_target dut (
        .clk(clk), .rst_n(rst_n), .scl(scl), .sda_in(sda_in), .sda_oe(sda_oe),
        .prox_val(prox_val), .als0_val(als0_val), .als1_val(als1_val),
        .mode_ctrl(mode_ctrl), .als_ps_ctrl(als_ps_ctrl), .ps_ctrl(ps_ctrl),
        .wr_strobe(wr_strobe), .busy(busy)
    );

    always #10 clk = ~clk;

    always @(posedge clk) begin
        if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
        if (sda_oe)    oe_cnt     <= oe_cnt + 1;
        if (busy)      busy_cnt   <= busy_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] m_reg(input logic [7:0] a);
        logic [47:0] sh;
        if (a == 8'h40) return 8'h0A;
        if (a == 8'h41) return m_mode;
        if (a == 8'h42) return m_alsps;
        if (a == 8'h43) return m_ps;
        if (a >= 8'h44 && a <= 8'h49) begin
            sh = m_snap >> (int'(a - 8'h44) * 8);
            return sh[7:0];
        end
        return 8'h00;
    endfunction

    task automatic m_write(input logic [7:0] ptr, input logic [7:0] data[$]);
        m_ptr = ptr;
        foreach (data[k]) begin
            if (m_ptr == 8'h41) m_mode  = data[k];
            if (m_ptr == 8'h42) m_alsps = data[k];
            if (m_ptr == 8'h43) m_ps    = data[k];
            m_ptr = m_ptr + 8'd1;
        end
    endtask

    // ---------------- bus primitives ----------------
    task automatic q_wait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; q_wait();
        scl = 1'b1;   q_wait();
        sda_m = 1'b0; q_wait();
        scl = 1'b0;   q_wait();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; q_wait();
        scl = 1'b1;   q_wait();
        sda_m = 1'b1; q_wait();
    endtask

    task automatic clock_bit(input logic b, output logic s);
        sda_m = b;  q_wait();
        scl = 1'b1; q_wait();
        s = sda_in; q_wait();
        scl = 1'b0; q_wait();
    endtask

    task automatic tx_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic rx_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(nack, s);
        sda_m = 1'b1;
    endtask

    task automatic i2c_write(input logic [6:0] addr, input logic [7:0] ptr,
                             input logic [7:0] data[$], input logic do_stop, output int acks);
        logic a;
        acks = 0;
        bus_start();
        tx_byte({addr, 1'b0}, a); acks += int'(a);
        tx_byte(ptr, a);          acks += int'(a);
        foreach (data[k]) begin
            tx_byte(data[k], a);
            acks += int'(a);
        end
        if (do_stop) bus_stop();
    endtask

    task automatic i2c_read(input int n, output logic aack, output logic [7:0] d[$]);
        logic [7:0] b;
        d = {};
        bus_start();
        tx_byte({DEV, 1'b1}, aack);
        for (int k = 0; k < n; k++) begin
            rx_byte(k == n - 1, b);
            d.push_back(b);
        end
        bus_stop();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe: got %b expected 0", sda_oe); end
        n_checks++; if (mode_ctrl !== 8'h00) begin n_fail++; $display("FAIL reset_mode: got %h expected 00", mode_ctrl); end
        n_checks++; if (als_ps_ctrl !== 8'h02) begin n_fail++; $display("FAIL reset_als_ps: got %h expected 02", als_ps_ctrl); end
        n_checks++; if (ps_ctrl !== 8'h01) begin n_fail++; $display("FAIL reset_ps: got %h expected 01", ps_ctrl); end
        n_checks++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_strobe: got %b expected 0", wr_strobe); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    endtask

    task automatic test_part_id();
        logic aack;
        logic [7:0] got[$];
        i2c_read(1, aack, got);
        n_checks++; if (aack !== 1'b1) begin n_fail++; $display("FAIL partid_ack: got %b expected 1", aack); end
        n_checks++; if (got[0] !== 8'h0A) begin n_fail++; $display("FAIL partid_value: got %h expected 0a", got[0]); end
    endtask

    task automatic test_write_mode();
        logic a0, a1, a2;
        int s0;
        logic [7:0] d[$];
        s0 = strobe_cnt;
        bus_start();
        tx_byte(8'h70, a0);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy: got %b expected 1", busy); end
        tx_byte(8'h41, a1);
        tx_byte(8'hC6, a2);
        bus_stop();
        d = {8'hC6};
        m_write(8'h41, d);
        n_checks++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL write_acks: got %b expected 111", {a0, a1, a2}); end
        n_checks++; if (mode_ctrl !== m_mode) begin n_fail++; $display("FAIL write_mode: got %h expected %h", mode_ctrl, m_mode); end
        n_checks++; if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL write_strobe: got %0d expected 1", strobe_cnt - s0); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_idle: got %b expected 0", busy); end
    endtask

    task automatic test_repeated_start_read();
        int acks;
        logic a;
        logic [7:0] b0, b1;
        logic [7:0] none[$];
        none = {};
        prox_val = 16'h1234;
        i2c_write(DEV, 8'h44, none, 1'b0, acks);
        bus_start();
        tx_byte({DEV, 1'b1}, a);
        rx_byte(1'b0, b0);
        rx_byte(1'b1, b1);
        n_checks++; if (acks !== 2 || a !== 1'b1) begin n_fail++; $display("FAIL rs_acks: got %0d/%b expected 2/1", acks, a); end
        n_checks++; if (b0 !== 8'h34) begin n_fail++; $display("FAIL rs_byte0: got %h expected 34", b0); end
        n_checks++; if (b1 !== 8'h12) begin n_fail++; $display("FAIL rs_byte1: got %h expected 12", b1); end
        n_checks++; if (sda_oe !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rs_release: got oe=%b busy=%b expected 0/0", sda_oe, busy); end
        bus_stop();
    endtask

    task automatic test_wrong_addr();
        logic a0, a1, a2;
        int oe0, bz0;
        oe0 = oe_cnt; bz0 = busy_cnt;
        bus_start();
        tx_byte(8'h72, a0);
        tx_byte(8'h41, a1);
        tx_byte(8'h55, a2);
        bus_stop();
        n_checks++; if (a0 !== 1'b0) begin n_fail++; $display("FAIL wrongaddr_ack: got %b expected 0", a0); end
        n_checks++; if (oe_cnt - oe0 !== 0) begin n_fail++; $display("FAIL wrongaddr_oe: got %0d cycles expected 0", oe_cnt - oe0); end
        n_checks++; if (busy_cnt - bz0 !== 0) begin n_fail++; $display("FAIL wrongaddr_busy: got %0d cycles expected 0", busy_cnt - bz0); end
        n_checks++; if (mode_ctrl !== m_mode) begin n_fail++; $display("FAIL wrongaddr_mode: got %h expected %h", mode_ctrl, m_mode); end
    endtask

    task automatic test_snapshot();
        int acks;
        logic a;
        logic [7:0] b0, b1;
        logic [7:0] none[$];
        none = {};
        prox_val = 16'h00FF;
        i2c_write(DEV, 8'h44, none, 1'b0, acks);
        bus_start();
        tx_byte({DEV, 1'b1}, a);
        rx_byte(1'b0, b0);
        prox_val = 16'hFF00;
        rx_byte(1'b1, b1);
        bus_stop();
        n_checks++; if (b0 !== 8'hFF) begin n_fail++; $display("FAIL snap_byte0: got %h expected ff", b0); end
        n_checks++; if (b1 !== 8'h00) begin n_fail++; $display("FAIL snap_byte1: got %h expected 00", b1); end
    endtask

    task automatic test_readonly_write();
        int acks;
        logic aack;
        logic [7:0] d[$], got[$];
        prox_val = 16'hBEEF;
        d = {8'h5A};
        i2c_write(DEV, 8'h44, d, 1'b1, acks);
        m_write(8'h44, d);
        n_checks++; if (acks !== 3) begin n_fail++; $display("FAIL ro_acks: got %0d expected 3", acks); end
        d = {};
        i2c_write(DEV, 8'h44, d, 1'b0, acks);
        m_ptr = 8'h44; m_snap = {als1_val, als0_val, prox_val};
        i2c_read(1, aack, got);
        n_checks++; if (got[0] !== m_reg(8'h44)) begin n_fail++; $display("FAIL ro_readback: got %h expected %h", got[0], m_reg(8'h44)); end
    endtask

    task automatic test_pointer_wrap();
        int acks;
        logic aack;
        logic [7:0] d[$], got[$];
        logic [7:0] exp;
        d = {};
        prox_val = 16'($urandom); als0_val = 16'($urandom); als1_val = 16'($urandom);
        i2c_write(DEV, 8'hFF, d, 1'b0, acks);
        m_ptr = 8'hFF; m_snap = {als1_val, als0_val, prox_val};
        i2c_read(67, aack, got);
        foreach (got[k]) begin
            exp = m_reg(m_ptr + 8'(k));
            n_checks++; if (got[k] !== exp) begin n_fail++; $display("FAIL wrap_byte%0d: got %h expected %h", k, got[k], exp); end
        end
    endtask

    task automatic test_random();
        logic [7:0] ptr, exp;
        logic [7:0] data[$], got[$];
        int n, acks, s0;
        logic aack;
        for (int it = 0; it < 10; it++) begin
            ptr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(8'h3E, 8'h4B));
            n = $urandom_range(1, 3);
            data = {};
            if ($urandom_range(0, 1) == 0) begin
                for (int k = 0; k < n; k++) data.push_back(8'($urandom));
                s0 = strobe_cnt;
                i2c_write(DEV, ptr, data, 1'b1, acks);
                m_write(ptr, data);
                n_checks++; if (acks !== n + 2) begin n_fail++; $display("FAIL rnd_wacks: got %0d expected %0d", acks, n + 2); end
                n_checks++; if (strobe_cnt - s0 !== n) begin n_fail++; $display("FAIL rnd_strobe: got %0d expected %0d", strobe_cnt - s0, n); end
            end else begin
                prox_val = 16'($urandom); als0_val = 16'($urandom); als1_val = 16'($urandom);
                i2c_write(DEV, ptr, data, 1'b0, acks);
                m_ptr = ptr; m_snap = {als1_val, als0_val, prox_val};
                i2c_read(n, aack, got);
                n_checks++; if (aack !== 1'b1) begin n_fail++; $display("FAIL rnd_raack: got %b expected 1", aack); end
                foreach (got[k]) begin
                    exp = m_reg(m_ptr + 8'(k));
                    n_checks++; if (got[k] !== exp) begin n_fail++; $display("FAIL rnd_read ptr=%h k=%0d: got %h expected %h", ptr, k, got[k], exp); end
                end
                m_ptr = m_ptr + 8'(n - 1);
            end
        end
        n_checks++; if ({mode_ctrl, als_ps_ctrl, ps_ctrl} !== {m_mode, m_alsps, m_ps})
            begin n_fail++; $display("FAIL rnd_regs: got %h expected %h", {mode_ctrl, als_ps_ctrl, ps_ctrl}, {m_mode, m_alsps, m_ps}); end
    endtask

    task automatic test_reset_mid_read();
        int acks;
        logic a;
        logic aack;
        logic [7:0] d[$], got[$];
        d = {8'hC6};
        i2c_write(DEV, 8'h41, d, 1'b1, acks);
        m_write(8'h41, d);
        prox_val = 16'h0000;
        d = {};
        i2c_write(DEV, 8'h44, d, 1'b0, acks);
        bus_start();
        tx_byte({DEV, 1'b1}, a);
        sda_m = 1'b1; q_wait();
        scl = 1'b1;   q_wait();
        n_checks++; if (sda_oe !== 1'b1) begin n_fail++; $display("FAIL midrd_driving: got %b expected 1", sda_oe); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (sda_oe !== 1'b0) begin n_fail++; $display("FAIL midrd_release: got %b expected 0", sda_oe); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrd_busy: got %b expected 0", busy); end
        q_wait();
        n_checks++; if (mode_ctrl !== 8'h00) begin n_fail++; $display("FAIL midrd_mode: got %h expected 00", mode_ctrl); end
        @(negedge clk) rst_n = 1'b1;
        m_mode = 8'h00; m_alsps = 8'h02; m_ps = 8'h01; m_ptr = 8'h40;
        q_wait();
        i2c_read(1, aack, got);
        n_checks++; if (got[0] !== m_reg(m_ptr)) begin n_fail++; $display("FAIL midrd_ptr_reset: got %h expected %h", got[0], m_reg(m_ptr)); end
    endtask

`ifdef I2C_TGT_GLITCH_FILTER_EN
    task automatic test_glitch();
        logic a;
        int oe0;
        oe0 = oe_cnt;
        scl = 1'b1; sda_m = 1'b1; q_wait();
        @(negedge clk) sda_m = 1'b0;
        @(negedge clk) sda_m = 1'b1;
        q_wait();
        scl = 1'b0; q_wait();
        tx_byte({DEV, 1'b0}, a);
        bus_stop();
        n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL glitch_ack: got %b expected 0", a); end
        n_checks++; if (oe_cnt - oe0 !== 0) begin n_fail++; $display("FAIL glitch_oe: got %0d expected 0", oe_cnt - oe0); end
    endtask
`endif

    initial begin
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        test_reset();
        test_part_id();
        test_write_mode();
        test_repeated_start_read();
        test_wrong_addr();
        test_snapshot();
        test_readonly_write();
        test_random();
        test_pointer_wrap();
        test_reset_mid_read();
`ifdef I2C_TGT_GLITCH_FILTER_EN
        test_glitch();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
